// File: rtl/goldschmidt_divider_norm_if.sv
// Operand/result handshake bundle for the normalising Goldschmidt divider.
interface goldschmidt_divider_norm_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned EW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    q;
    logic signed [EW-1:0] exp;
    logic                div_by_zero;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, q, exp, div_by_zero, out_valid, busy
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, q, exp, div_by_zero, out_valid, busy
    );
endinterface

// File: rtl/goldschmidt_divider_norm.sv
// Goldschmidt fractional divider: normalises 0.a / 0.b with leading-zero counts,
// iterates, and returns a rounded 1.(WIDTH-1) mantissa plus exponent lb - la.
module goldschmidt_divider_norm #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 5,
    parameter int unsigned GUARD = 4
) (
    input  logic                         clk,
    input  logic                         clrn,
    goldschmidt_divider_norm_if.slave    bus
);

    localparam int unsigned EW = $clog2(WIDTH) + 1;
    localparam int unsigned FW = 2 * WIDTH;
    localparam int unsigned PW = 4 * WIDTH;
    localparam int unsigned RW = WIDTH + GUARD + 1;
    localparam int unsigned CW = $clog2(ITER + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_ROUND,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [EW-1:0]        la_q, la_d, lb_q, lb_d;
    logic [FW-1:0]        x_q, x_d, y_q, y_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic                 dz_q, dz_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    logic [FW-1:0]        f_c, x_mul_c, y_mul_c;
    logic [RW-1:0]        rnd_c;
    logic [EW-1:0]        la_c, lb_c;
    logic [WIDTH-1:0]     an_c, bn_c;

    function automatic logic [EW-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [EW-1:0] n;
        n = EW'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (v[i]) n = EW'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    // Shared datapath: f = 2 - y in 1.(FW-1) format, products truncated to one integer bit
    always_comb begin
        f_c     = FW'(0) - y_q;
        x_mul_c = FW'((PW'(x_q) * PW'(f_c)) >> (FW - 1));
        y_mul_c = FW'((PW'(y_q) * PW'(f_c)) >> (FW - 1));
        rnd_c   = RW'(x_mul_c >> (WIDTH - GUARD)) + (RW'(1) << (GUARD - 1));
        la_c    = lzc(a_q);
        lb_c    = lzc(b_q);
        an_c    = a_q << la_c;
        bn_c    = b_q << lb_c;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        la_d        = la_q;
        lb_d        = lb_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        exp_d       = exp_q;
        dz_d        = dz_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                la_d    = la_c;
                lb_d    = lb_c;
                x_d     = {1'b0, an_c, {(WIDTH-1){1'b0}}};
                y_d     = {1'b0, bn_c, {(WIDTH-1){1'b0}}};
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                x_d = x_mul_c;
                y_d = y_mul_c;
                if (cnt_q == CW'(ITER - 1)) state_d = S_ROUND;
                else                        cnt_d   = cnt_q + CW'(1);
            end
            S_ROUND: begin
                // x approaches the quotient from below; one more x*(2-y) refinement
                // here closes that gap so exactly representable quotients round exactly.
                out_valid_d = 1'b1;
                state_d     = S_DONE;
                if (b_q == '0) begin
                    q_d   = '1;
                    exp_d = '0;
                    dz_d  = 1'b1;
                end else if (a_q == '0) begin
                    q_d   = '0;
                    exp_d = '0;
                    dz_d  = 1'b0;
                end else begin
                    q_d   = rnd_c[RW-1] ? '1 : WIDTH'(rnd_c >> GUARD);
                    exp_d = $signed(lb_q - la_q);
                    dz_d  = 1'b0;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            la_q        <= '0;
            lb_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            exp_q       <= '0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            la_q        <= la_d;
            lb_q        <= lb_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            exp_q       <= exp_d;
            dz_q        <= dz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.q           = q_q;
    assign bus.exp         = exp_q;
    assign bus.div_by_zero = dz_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_goldschmidt_divider_norm.sv
// Scoreboarded bench for goldschmidt_divider_norm (WIDTH=32, ITER=5).
module tb_goldschmidt_divider_norm;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 5;
    localparam int unsigned GUARD = 4;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    goldschmidt_divider_norm_if #(.WIDTH(WIDTH)) bus ();

    goldschmidt_divider_norm #(
        .WIDTH (WIDTH),
        .ITER  (ITER),
        .GUARD (GUARD)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0]        lo;
        logic [31:0]        hi;
        logic signed [5:0]  e;
        logic               dz;
    } exp_t;

    exp_t               sb[$];
    int                 checks   = 0;
    int                 failures = 0;
    logic [31:0]        last_q;
    logic signed [5:0]  last_e;
    logic               last_dz;

    // Reference: normalise by shifting, exact quotient by integer division
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        int          la, lb;
        logic [31:0] an, bn;
        logic [63:0] num, den, fl, rem;
        r.e  = 6'sd0;
        r.dz = 1'b0;
        if (b == 32'd0) begin
            r.lo = 32'hFFFF_FFFF; r.hi = 32'hFFFF_FFFF; r.dz = 1'b1;
            return r;
        end
        if (a == 32'd0) begin
            r.lo = 32'd0; r.hi = 32'd0;
            return r;
        end
        la = 0; lb = 0; an = a; bn = b;
        while (!an[31]) begin an = an << 1; la++; end
        while (!bn[31]) begin bn = bn << 1; lb++; end
        num = {1'b0, an, 31'd0};
        den = {32'd0, bn};
        fl  = num / den;
        rem = num % den;
        r.e = 6'(lb - la);
        if (rem == 64'd0) begin
            r.lo = 32'(fl); r.hi = 32'(fl);
        end else begin
            r.lo = 32'(fl) - 32'd1;
            r.hi = (fl == 64'h0000_0000_FFFF_FFFF) ? 32'(fl) : 32'(fl) + 32'd1;
        end
        return r;
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold, input bit chk_lat);
        exp_t              e;
        int                lat;
        int                w;
        logic [31:0]       hq;
        logic signed [5:0] he;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL in_ready_wait: got %b want 1", bus.in_ready);
        end
        bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        e = sb.pop_front();
        if (bus.out_valid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL out_valid_timeout: a=%h b=%h no result after %0d cycles", a, b, lat);
            return;
        end
        if (chk_lat) begin
            checks++;
            if (lat != int'(ITER + 2)) begin
                failures++; $display("FAIL latency: got %0d want %0d", lat, ITER + 2);
            end
        end
        checks++;
        if ($isunknown(bus.q) || bus.q < e.lo || bus.q > e.hi) begin
            failures++; $display("FAIL q: a=%h b=%h got %h want [%h,%h]", a, b, bus.q, e.lo, e.hi);
        end
        checks++;
        if (bus.exp !== e.e) begin
            failures++; $display("FAIL exp: a=%h b=%h got %0d want %0d", a, b, bus.exp, e.e);
        end
        checks++;
        if (bus.div_by_zero !== e.dz) begin
            failures++; $display("FAIL div_by_zero: a=%h b=%h got %b want %b", a, b, bus.div_by_zero, e.dz);
        end
        last_q = bus.q; last_e = bus.exp; last_dz = bus.div_by_zero;
        hq = bus.q; he = bus.exp;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.a = $urandom; bus.b = $urandom;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
                bus.q !== hq || bus.exp !== he) begin
                failures++;
                $display("FAIL hold_stable: cyc=%0d ov=%b ir=%b busy=%b q=%h exp=%0d want ov=1 ir=0 busy=1 q=%h exp=%0d",
                         i, bus.out_valid, bus.in_ready, bus.busy, bus.q, bus.exp, hq, he);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL release: ov=%b ir=%b busy=%b want ov=0 ir=1 busy=0", bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: ov=%b busy=%b ir=%b want 0 0 1", bus.out_valid, bus.busy, bus.in_ready);
        end
        checks++;
        if (bus.q !== 32'd0 || bus.exp !== 6'sd0 || bus.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: q=%h exp=%0d dz=%b want 0 0 0", bus.q, bus.exp, bus.div_by_zero);
        end
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(32'hC000_0000, 32'h8000_0000, 0, 1'b1);
        checks++;
        if (last_q !== 32'hC000_0000 || last_e !== 6'sd0) begin
            failures++; $display("FAIL dir_1p5: q=%h exp=%0d want c0000000 0", last_q, last_e);
        end
        do_op(32'h4000_0000, 32'hC000_0000, 0, 1'b1);
        checks++;
        if (last_e !== -6'sd1 || last_q < 32'h5555_5554 || last_q > 32'h5555_5556) begin
            failures++; $display("FAIL dir_2_3: q=%h exp=%0d want 55555555+-1 -1", last_q, last_e);
        end
        do_op(32'h0000_0001, 32'h8000_0000, 0, 1'b1);
        checks++;
        if (last_q !== 32'h8000_0000 || last_e !== -6'sd31) begin
            failures++; $display("FAIL dir_small_a: q=%h exp=%0d want 80000000 -31", last_q, last_e);
        end
        do_op(32'h8000_0000, 32'h0000_0001, 0, 1'b1);
        checks++;
        if (last_q !== 32'h8000_0000 || last_e !== 6'sd31) begin
            failures++; $display("FAIL dir_small_b: q=%h exp=%0d want 80000000 31", last_q, last_e);
        end
    endtask

    task automatic test_zero();
        do_op(32'h1234_5678, 32'h0000_0000, 0, 1'b1);
        checks++;
        if (last_dz !== 1'b1 || last_q !== 32'hFFFF_FFFF || last_e !== 6'sd0) begin
            failures++; $display("FAIL zero_b: dz=%b q=%h exp=%0d want 1 ffffffff 0", last_dz, last_q, last_e);
        end
        do_op(32'h0000_0000, 32'h8000_0000, 0, 1'b1);
        checks++;
        if (last_dz !== 1'b0 || last_q !== 32'h0 || last_e !== 6'sd0) begin
            failures++; $display("FAIL zero_a: dz=%b q=%h exp=%0d want 0 0 0", last_dz, last_q, last_e);
        end
        do_op(32'h0000_0000, 32'h0000_0000, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        do_op(32'h9ABC_DEF0, 32'hA000_0000, 20, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.a = 32'h7000_0000; bus.b = 32'h9000_0000; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: busy=%b ov=%b ir=%b want 0 0 1", bus.busy, bus.out_valid, bus.in_ready);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL reset_discard: out_valid seen=%b want 0", seen);
        end
        do_op(32'h6000_0000, 32'h9000_0000, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_op(32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b1);
        do_op(32'h0001_0000, 32'h0000_0300, 0, 1'b1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
        do_op(32'h8000_0001, 32'hFFFF_FFFF, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 3000; n++) begin
            a = $urandom;
            b = $urandom;
            if (n[0]) a = a >> $urandom_range(0, 31);
            if (n[1]) b = b >> $urandom_range(0, 31);
            if (a == 32'd0) a = 32'd1;
            if (b == 32'd0) b = 32'd3;
            do_op(a, b, 0, n[4]);
        end
    endtask

    initial begin
        clrn = 1'b0;
        bus.a = '0; bus.b = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/goldschmidt_divider_norm.md
Name: goldschmidt_divider_norm

Overview:
- Parametrised Goldschmidt fractional divider with a valid/ready handshake on both sides.
- Accepts arbitrary unsigned fractions 0.xxx (not only the [0.5,1) range) and normalises both operands internally with leading-zero counts.
- Runs ITER Goldschmidt iterations and returns a rounded normalised mantissa plus a signed exponent, so that a/b = q * 2^exp.
- Feeds the team's fixed-point datapath, which re-scales using exp.

Parameters:
- WIDTH, 32, operand and mantissa width in bits.
- ITER, 5, number of Goldschmidt iterations (ITER >= 1).
- GUARD, 4, extra fraction bits carried internally below WIDTH for rounding.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  synchronous active-low reset.
- a  in  WIDTH  dividend, unsigned fraction 0.a.
- b  in  WIDTH  divisor, unsigned fraction 0.b.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- q  out  WIDTH  quotient mantissa, format 1.(WIDTH-1), value in [0.5,2).
- exp  out  $clog2(WIDTH)+1  signed exponent, lb - la.
- div_by_zero  out  1  b was zero.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- busy  out  1  operation in progress (state != IDLE).

Behaviour:
- Reset: clrn sampled low at a rising clk edge forces state IDLE and clears q, exp, div_by_zero, out_valid and busy to 0; in_ready is 1 after reset.
- Reset mid-operation or while DONE discards the result with no output.
- States and transitions:
  - IDLE: in_ready=1. An edge with in_valid=1 latches a and b and moves to NORM.
  - NORM (1 cycle): la = lzc(a), lb = lzc(b). an = a<<la, bn = b<<lb, placed in 2*WIDTH-bit registers with format x.xxx, as 0.1xxx. Then move to ITER.
  - ITER (ITER cycles): per cycle f = 2 - y; x <= x*f, y <= y*f. Products are truncated back to 2*WIDTH bits keeping 1 integer bit. An internal counter counts 0..ITER-1. Then move to ROUND.
  - ROUND (1 cycle): q = x rounded to nearest (half up) at the WIDTH-1 fraction position using the GUARD bits. If rounding overflows to 2.0, saturate to all-ones. Set exp = lb - la, set out_valid=1, move to DONE.
  - DONE: hold q, exp, div_by_zero and out_valid stable until out_ready=1 at an edge, then clear out_valid and go to IDLE.
- Latency: out_valid rises ITER+2 edges after the accepting edge. Back-pressure is unlimited.
- No new operands are accepted until DONE completes. in_valid outside IDLE is ignored, with no queueing.
- Zero operands take the same fixed latency:
  - b == 0: div_by_zero=1, q = all-ones, exp=0.
  - a == 0 with b != 0: q=0, exp=0, div_by_zero=0.
  - a == 0 and b == 0: div_by_zero=1.
- Accuracy: q is within 1 LSB of the exact an/bn for ITER >= ceil(log2(WIDTH)). Exactly representable quotients must be bit-exact.
- Simultaneous events:
  - Reset has priority over all handshakes.
  - out_ready in a non-DONE state is ignored.

Test Plan:
- WIDTH=32. a=0xC0000000, b=0x80000000 -> q=0xC0000000 (1.5), exp=0, div_by_zero=0, out_valid exactly 7 edges after accept.
- a=0x40000000, b=0xC0000000 -> la=1, lb=0, q=0x55555555 (±1 LSB), exp=-1.
- a=0x00000001, b=0x80000000 -> q=0x80000000, exp=-31. Then a=0x80000000, b=0x00000001 -> q=0x80000000, exp=+31.
- b=0 with a=0x12345678 -> div_by_zero=1, q=0xFFFFFFFF, exp=0. Then a=0, b=0x80000000 -> q=0, exp=0, div_by_zero=0.
- Hold out_ready=0 for 20 cycles while toggling in_valid -> outputs stable, in_ready=0, no second accept. Then out_ready=1 -> out_valid drops, in_ready=1 next cycle.
- Assert clrn=0 for 1 cycle during ITER -> next edge: state IDLE, out_valid=0, busy=0. A new operation after reset completes correctly.
- Random regression: 10k normalised and unnormalised non-zero pairs vs. a reference model, error <= 1 LSB, for WIDTH=16/ITER=4 and WIDTH=32/ITER=5.
